eq_gain_ramp: RTL
=================

Name: eq_gain_ramp

Overview:
- Upstream control stage for the 10-band equalizer; produces `gain_1..gain_10`, which feed the equalizer gain inputs directly.
- Holds one target gain per band, loaded through a valid/ready write port.
- Once per audio sample (`sample_tick`), moves each live gain toward its target by at most `STEP`. This stops zipper noise when gains change.
- New gain sets are committed atomically, so the equalizer never sees a half-updated set.

Parameters:
- `GAIN_WIDTH`, 13: width of each gain word (unsigned).
- `NUM_BANDS`, 10: number of bands; fixed to 10 by the port list.
- `STEP`, 8: maximum change of one gain per sample tick (unsigned, ≥1).
- `GAIN_RESET`, 4096: target and live gain value after reset.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sample_tick` input 1: one-cycle strobe, one per audio sample.
- `wr_valid` input 1: write request.
- `wr_ready` output 1: write accepted when `wr_valid` && `wr_ready`.
- `wr_band` input 4: band index 0..9 (band 0 drives `gain_1`).
- `wr_gain` input `GAIN_WIDTH`: new target gain.
- `clr_flags` input 1: clears sticky flags.
- `gain_1` .. `gain_10` output `GAIN_WIDTH` each: committed live gains, registered.
- `ramp_busy` output 1: at least one committed gain differs from its target.
- `err_bad_band` output 1: sticky; a write with `wr_band` ≥ 10 was dropped.
- `err_overrun` output 1: sticky; a `sample_tick` arrived while a scan was in progress.

Behaviour:
- Reset (`rst`=1 at an edge):
  - all targets, shadow gains and `gain_*` = `GAIN_RESET`.
  - `ramp_busy`=0, both error flags=0, FSM=IDLE, scan index=0.
  - `wr_ready`=0 during the reset cycle, 1 on every cycle after.
  - Reset mid-scan discards all shadow progress.
- Write port:
  - Accepted on any non-reset edge with `wr_valid`=1, independent of FSM state.
  - `wr_band` 0..9: `target[wr_band]` <= `wr_gain`.
  - `wr_band` ≥ 10: write dropped, `err_bad_band` <= 1.
  - One write per cycle. A later write to the same band overwrites the earlier one.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE: `sample_tick`=1 at edge E0 moves to SCAN with index 0.
  - SCAN: at edge E(k+1), k=0..9, band k's shadow is updated from that band's current shadow and target. Index 9 goes to COMMIT.
  - COMMIT (edge E11): all `gain_*` <= shadow, `ramp_busy` <= (any shadow ≠ its target, using target values as of E11), then back to IDLE.
  - Next tick is accepted from edge E12 onward. Tick-to-output latency is 12 edges.
- Ramp arithmetic (unsigned, computed `GAIN_WIDTH`+1 bits wide so it cannot wrap):
  - if shadow < target: shadow <= min(shadow + `STEP`, target).
  - if shadow > target: shadow <= max(shadow − `STEP`, target).
  - if equal: unchanged.
  - Never overshoots. Never wraps at 0 or 2^`GAIN_WIDTH`−1.
- Write/scan collision:
  - A write to band k on the same edge band k is scanned: the scan uses the old target, the new target is stored.
  - The new target takes effect on the next tick, or on the current tick if band k has not yet been scanned.
- `sample_tick` on E1..E11 (SCAN/COMMIT): tick ignored, `err_overrun` <= 1. Does not extend or restart the scan.
- `clr_flags`=1: both flags <= 0. If an error event occurs on the same edge, the set wins (flag = 1).
- `gain_*` change only on a COMMIT edge or on reset.

Test Plan:
- Reset: assert `rst` 2 cycles → all `gain_*`=4096, `ramp_busy`=0, `wr_ready`=0 then 1, both flags 0.
- Ramp up: write band 2 target 4120, then 4 ticks spaced 20 cycles → `gain_3` = 4104, 4112, 4120, 4120. `ramp_busy`=1,1,0,0. Each update visible 12 edges after its tick.
- Ramp down / clamp at zero: `GAIN_RESET` overridden to 5, write band 0 target 0, one tick → `gain_1`=0 with no wrap. Write band 9 target 8191 from 8190 with `STEP`=8 → `gain_10`=8191 after one tick.
- Overrun: tick, then a second tick 5 cycles later → single update, `err_overrun`=1. `clr_flags` pulse → 0. `clr_flags` coincident with a new overrun → stays 1.
- Bad band / collision: write `wr_band`=12 → no gain change, `err_bad_band`=1. Write band 5 on edge E6 of a scan → band 5 keeps its old ramp this tick, follows the new target on the next tick.
- Reset mid-scan: assert `rst` at E5 after targets were changed → all outputs 4096, FSM IDLE. Next tick ramps from 4096 toward 4096 (no change).

Source files
------------

// File: rtl/eq_gain_ramp.sv
// eq_gain_ramp
// Control stage ahead of the 10-band equalizer. Holds one target gain per
// band and, once per audio sample, walks every live gain toward its target by
// at most STEP. The walk runs on a private shadow copy, one band per cycle.
// All ten outputs are then committed together, so the equalizer never sees a
// partially updated set.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   sample_tick   one-cycle strobe per audio sample; starts a scan when idle
//   wr_valid      target write request
//   wr_ready      write acceptance (low only while rst is high)
//   wr_band       band index 0..9; band 0 drives gain_1
//   wr_gain       new target gain
//   clr_flags     clears both sticky error flags (a same-cycle error wins)
//   gain_1..10    committed live gains (registered)
//   ramp_busy     some committed gain still differs from its target
//   err_bad_band  sticky: a write to a band >= 10 was dropped
//   err_overrun   sticky: a sample_tick arrived while a scan was running
//   dbg_state     current FSM state (IDLE=0, SCAN=1, COMMIT=2)
//
// Write handshake: a write transfers on a rising edge where wr_valid and
// wr_ready are both high. wr_ready is low only while rst is high, so no
// scan or commit activity ever stalls the write port.
module eq_gain_ramp #(
  parameter int GAIN_WIDTH = 13,
  parameter int NUM_BANDS  = 10,
  parameter int STEP       = 8,
  parameter int GAIN_RESET = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_band,
  input  logic [GAIN_WIDTH-1:0] wr_gain,
  input  logic                  clr_flags,
  output logic [GAIN_WIDTH-1:0] gain_1,
  output logic [GAIN_WIDTH-1:0] gain_2,
  output logic [GAIN_WIDTH-1:0] gain_3,
  output logic [GAIN_WIDTH-1:0] gain_4,
  output logic [GAIN_WIDTH-1:0] gain_5,
  output logic [GAIN_WIDTH-1:0] gain_6,
  output logic [GAIN_WIDTH-1:0] gain_7,
  output logic [GAIN_WIDTH-1:0] gain_8,
  output logic [GAIN_WIDTH-1:0] gain_9,
  output logic [GAIN_WIDTH-1:0] gain_10,
  output logic                  ramp_busy,
  output logic                  err_bad_band,
  output logic                  err_overrun,
  output logic [1:0]            dbg_state
);

  localparam logic [GAIN_WIDTH-1:0] RST_VAL = GAIN_RESET[GAIN_WIDTH-1:0];
  localparam logic [GAIN_WIDTH:0]   STEP_W  = STEP[GAIN_WIDTH:0];
  localparam logic [3:0]            LAST    = 4'(NUM_BANDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                state_q;
  logic [3:0]            idx_q;
  logic [GAIN_WIDTH-1:0] target_q [NUM_BANDS];
  logic [GAIN_WIDTH-1:0] shadow_q [NUM_BANDS];
  logic [GAIN_WIDTH-1:0] gain_q   [NUM_BANDS];
  logic                  busy_q;
  logic                  bad_band_q;
  logic                  overrun_q;
  logic                  any_diff;

  // One ramp step, evaluated one bit wider than a gain so neither the
  // add near full scale nor the subtract near zero can wrap.
  function automatic logic [GAIN_WIDTH-1:0] ramp_step(
    input logic [GAIN_WIDTH-1:0] s,
    input logic [GAIN_WIDTH-1:0] t
  );
    logic [GAIN_WIDTH:0] sw;
    logic [GAIN_WIDTH:0] tw;
    logic [GAIN_WIDTH:0] up;
    logic [GAIN_WIDTH:0] gap;
    sw        = {1'b0, s};
    tw        = {1'b0, t};
    up        = sw + STEP_W;
    gap       = sw - tw;
    ramp_step = s;
    if (sw < tw) begin
      ramp_step = (up > tw) ? t : up[GAIN_WIDTH-1:0];
    end else if (sw > tw) begin
      ramp_step = (gap > STEP_W) ? (s - STEP_W[GAIN_WIDTH-1:0]) : t;
    end
  endfunction

  // Compares against the targets as they stand at the commit edge, so a
  // write landing during the scan is reflected in ramp_busy.
  always_comb begin
    any_diff = 1'b0;
    for (int b = 0; b < NUM_BANDS; b++) begin
      if (shadow_q[b] != target_q[b]) any_diff = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      busy_q     <= 1'b0;
      bad_band_q <= 1'b0;
      overrun_q  <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        target_q[b] <= RST_VAL;
        shadow_q[b] <= RST_VAL;
        gain_q[b]   <= RST_VAL;
      end
    end else begin
      // Write port. The scan below reads target_q before this edge, so a
      // write to the band being scanned only affects later ticks.
      if (wr_valid) begin
        if (wr_band < 4'(NUM_BANDS)) begin
          target_q[wr_band] <= wr_gain;
        end
      end

      // Sticky flags: the error event takes priority over the clear.
      if (wr_valid && (wr_band >= 4'(NUM_BANDS))) begin
        bad_band_q <= 1'b1;
      end else if (clr_flags) begin
        bad_band_q <= 1'b0;
      end

      if (sample_tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clr_flags) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            state_q <= SCAN;
            idx_q   <= 4'd0;
          end
        end
        SCAN: begin
          shadow_q[idx_q] <= ramp_step(shadow_q[idx_q], target_q[idx_q]);
          if (idx_q == LAST) begin
            state_q <= COMMIT;
            idx_q   <= 4'd0;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        COMMIT: begin
          for (int b = 0; b < NUM_BANDS; b++) begin
            gain_q[b] <= shadow_q[b];
          end
          busy_q  <= any_diff;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= 4'd0;
        end
      endcase
    end
  end

  assign wr_ready     = ~rst;
  assign ramp_busy    = busy_q;
  assign err_bad_band = bad_band_q;
  assign err_overrun  = overrun_q;
  assign dbg_state    = state_q;

  assign gain_1  = gain_q[0];
  assign gain_2  = gain_q[1];
  assign gain_3  = gain_q[2];
  assign gain_4  = gain_q[3];
  assign gain_5  = gain_q[4];
  assign gain_6  = gain_q[5];
  assign gain_7  = gain_q[6];
  assign gain_8  = gain_q[7];
  assign gain_9  = gain_q[8];
  assign gain_10 = gain_q[9];

endmodule
